// File: rtl/uart_rx_cfg.sv
// Parameterised UART receiver: 2-flop RX sync, start-bit glitch reject, optional parity, 1-2 stop bits.
// Latency: rdy rises 1 clk after the final stop-bit sample (mid stop bit).
// No backpressure: rdy is a level acknowledged by clr_rdy; an unacknowledged frame is overwritten and overrun is set.
module uart_rx_cfg #(
    parameter int CLK_DIV    = 2604,
    parameter int DATA_BITS  = 8,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 RX,
    input  logic                 clr_rdy,
    output logic                 rdy,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun
);

    localparam int CNT_W = $clog2(CLK_DIV + 1);
    localparam logic [CNT_W-1:0] HALF_CNT  = CNT_W'(CLK_DIV / 2);
    localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [3:0]       LAST_DATA = 4'(DATA_BITS - 1);
    localparam logic [3:0]       LAST_STOP = 4'(STOP_BITS - 1);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] START  = 3'd1;
    localparam logic [2:0] DATA   = 3'd2;
    localparam logic [2:0] PARITY = 3'd3;
    localparam logic [2:0] STOP   = 3'd4;

    logic                 rx_meta;
    logic                 rxs;
    logic [2:0]           state;
    logic [CNT_W-1:0]     baud_cnt;
    logic [3:0]           bit_cnt;
    logic [DATA_BITS-1:0] shreg;
    logic                 par_bad;
    logic                 stop_bad;
    logic                 line_armed;
    logic                 done;
    logic                 tick;

    assign tick = (baud_cnt == FULL_CNT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
        end else begin
            rx_meta <= RX;
            rxs     <= rx_meta;
        end
    end

    // line_armed blocks a new start after a frame whose last stop sample was low
    // (break), until the line has been seen high again.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            baud_cnt   <= '0;
            bit_cnt    <= '0;
            shreg      <= '0;
            par_bad    <= 1'b0;
            stop_bad   <= 1'b0;
            line_armed <= 1'b1;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (rxs) begin
                        line_armed <= 1'b1;
                    end else if (line_armed) begin
                        state    <= START;
                        baud_cnt <= '0;
                    end
                end
                START: begin
                    if (baud_cnt == HALF_CNT) begin
                        baud_cnt <= '0;
                        bit_cnt  <= '0;
                        par_bad  <= 1'b0;
                        stop_bad <= 1'b0;
                        state    <= rxs ? IDLE : DATA;
                    end else begin
                        baud_cnt <= baud_cnt + CNT_ONE;
                    end
                end
                DATA: begin
                    if (tick) begin
                        baud_cnt <= '0;
                        shreg    <= {rxs, shreg[DATA_BITS-1:1]};
                        if (bit_cnt == LAST_DATA) begin
                            bit_cnt <= '0;
                            state   <= (PARITY_EN != 0) ? PARITY : STOP;
                        end else begin
                            bit_cnt <= bit_cnt + 4'd1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + CNT_ONE;
                    end
                end
                PARITY: begin
                    if (tick) begin
                        baud_cnt <= '0;
                        par_bad  <= (^shreg) ^ rxs ^ (PARITY_ODD != 0);
                        state    <= STOP;
                    end else begin
                        baud_cnt <= baud_cnt + CNT_ONE;
                    end
                end
                STOP: begin
                    if (tick) begin
                        baud_cnt <= '0;
                        stop_bad <= stop_bad | ~rxs;
                        if (bit_cnt == LAST_STOP) begin
                            bit_cnt    <= '0;
                            state      <= IDLE;
                            done       <= 1'b1;
                            line_armed <= rxs;
                        end else begin
                            bit_cnt <= bit_cnt + 4'd1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + CNT_ONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Completion takes priority over clr_rdy in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_data    <= '0;
            rdy        <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
        end else if (done) begin
            rx_data    <= shreg;
            rdy        <= 1'b1;
            parity_err <= par_bad;
            frame_err  <= stop_bad;
            overrun    <= clr_rdy ? 1'b0 : (overrun | rdy);
        end else if (clr_rdy) begin
            rdy        <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
        end
    end

endmodule
